// File: rtl/sdram_aref_if.sv
// Auto-refresh handshake bundle between sdram_aref and its upstream init/arbiter logic.
// The 20-bit bus uses the same packing as init_bus: {cs_n,ras_n,cas_n,we_n, cke, a[12:0], ba[1:0]}.
interface sdram_aref_if;
   logic        init_done;
   logic        ref_en;
   logic        ref_req;
   logic        ref_done;
   logic        ref_overrun;
   logic [19:0] aref_bus;

   // Arbiter / init side: supplies init_done and the grant, observes the refresh engine.
   modport master (
      output init_done,
      output ref_en,
      input  ref_req,
      input  ref_done,
      input  ref_overrun,
      input  aref_bus
   );

   // Refresh engine side.
   modport slave (
      input  init_done,
      input  ref_en,
      output ref_req,
      output ref_done,
      output ref_overrun,
      output aref_bus
   );
endinterface

// File: rtl/sdram_aref.sv
// SDRAM auto-refresh engine: times the refresh interval once initialization is done,
// accumulates owed refreshes, and on grant issues PRECHARGE-ALL followed by NUM_REF
// AUTO-REFRESH commands with tRP/tRC spacing.
module sdram_aref #(
   parameter int T_REFI  = 780,
   parameter int T_RP    = 2,
   parameter int T_RC    = 7,
   parameter int NUM_REF = 1
) (
   input  logic         clk,
   input  logic         rst,
   sdram_aref_if.slave  io
);

   localparam int TW     = $clog2(T_REFI);
   localparam int T_WMAX = (T_RP > T_RC) ? T_RP : T_RC;
   localparam int WW     = (T_WMAX > 2) ? $clog2(T_WMAX) : 1;
   localparam int RCW    = 3;

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_REF = 4'b0001;

   localparam logic [19:0] NOP_BUS = {CMD_NOP, 1'b1, 13'h0000, 2'b00};
   localparam logic [19:0] PRE_BUS = {CMD_PRE, 1'b1, 13'h0400, 2'b00};
   localparam logic [19:0] REF_BUS = {CMD_REF, 1'b1, 13'h0000, 2'b00};

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_WAIT_RP,
      S_REF,
      S_WAIT_RC,
      S_DONE
   } state_e;

   state_e           state;
   logic [TW-1:0]    timer;
   logic             tick;
   logic [1:0]       pend;
   logic [1:0]       pend_nxt;
   logic             overrun_set;
   logic             req_q;
   logic             done_q;
   logic             ovr_q;
   logic [19:0]      bus_q;
   logic [WW-1:0]    wcnt;
   logic [RCW-1:0]   rcnt;
   logic             dec;

   assign tick = io.init_done && (timer == TW'(T_REFI - 1));
   assign dec  = done_q && (pend != 2'd0);

   // Interval timer: held at zero until init completes, then free-runs with period T_REFI.
   // NOTE: every register update in clocked blocks uses <= so all flops sample pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         timer <= '0;
      else if (!io.init_done || tick)
         timer <= '0;
      else
         timer <= timer + 1'b1;
   end

   // Next pending-refresh count: a tick adds one, a completed sequence removes one, both cancel.
   // NOTE: outputs of a combinational block get a default first so no path leaves them unassigned (no latch).
   always_comb begin
      pend_nxt    = pend;
      overrun_set = 1'b0;
      case ({tick, dec})
         2'b10: begin
            if (pend == 2'd3)
               overrun_set = 1'b1;
            else
               pend_nxt = pend + 2'd1;
         end
         2'b01:   pend_nxt = pend - 2'd1;
         default: pend_nxt = pend;
      endcase
   end

   // Pending counter, its registered request flag and the sticky overrun flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend  <= 2'd0;
         req_q <= 1'b0;
         ovr_q <= 1'b0;
      end else if (!io.init_done) begin
         pend  <= 2'd0;
         req_q <= 1'b0;
      end else begin
         pend  <= pend_nxt;
         req_q <= (pend_nxt != 2'd0);
         if (overrun_set)
            ovr_q <= 1'b1;
      end
   end

   // Sequencer FSM with registered command bus and done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         wcnt   <= '0;
         rcnt   <= '0;
         bus_q  <= NOP_BUS;
         done_q <= 1'b0;
      end else begin
         bus_q  <= NOP_BUS;
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (io.ref_en && req_q) begin
                  state <= S_PRE;
                  bus_q <= PRE_BUS;
                  rcnt  <= '0;
               end
            end
            S_PRE: begin
               if (T_RP > 1) begin
                  state <= S_WAIT_RP;
                  wcnt  <= WW'(T_RP - 2);
               end else begin
                  state <= S_REF;
                  bus_q <= REF_BUS;
                  rcnt  <= rcnt + 1'b1;
               end
            end
            S_WAIT_RP: begin
               if (wcnt == '0) begin
                  state <= S_REF;
                  bus_q <= REF_BUS;
                  rcnt  <= rcnt + 1'b1;
               end else begin
                  wcnt <= wcnt - 1'b1;
               end
            end
            S_REF: begin
               if (T_RC > 1) begin
                  state <= S_WAIT_RC;
                  wcnt  <= WW'(T_RC - 2);
               end else if (rcnt < RCW'(NUM_REF)) begin
                  state <= S_REF;
                  bus_q <= REF_BUS;
                  rcnt  <= rcnt + 1'b1;
               end else begin
                  state  <= S_DONE;
                  done_q <= 1'b1;
               end
            end
            S_WAIT_RC: begin
               if (wcnt != '0) begin
                  wcnt <= wcnt - 1'b1;
               end else if (rcnt < RCW'(NUM_REF)) begin
                  state <= S_REF;
                  bus_q <= REF_BUS;
                  rcnt  <= rcnt + 1'b1;
               end else begin
                  state  <= S_DONE;
                  done_q <= 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign io.ref_req     = req_q;
   assign io.ref_done    = done_q;
   assign io.ref_overrun = ovr_q;
   assign io.aref_bus    = bus_q;

endmodule

// File: tb/tb_sdram_aref.sv
// Directed bench for sdram_aref. Stimulus pushes the expected command/done events with
// their absolute cycle numbers; per-DUT monitors pop and compare whenever a non-NOP
// command or a ref_done pulse appears on the bus.
module tb_sdram_aref;

   localparam logic [19:0] NOP_BUS = {4'b0111, 1'b1, 13'h0000, 2'b00};
   localparam logic [19:0] PRE_BUS = {4'b0010, 1'b1, 13'h0400, 2'b00};
   localparam logic [19:0] REF_BUS = {4'b0001, 1'b1, 13'h0000, 2'b00};

   typedef struct {
      int          cyc;
      logic [19:0] bus;
      logic        done;
   } evt_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   evt_t q_a[$];
   evt_t q_b[$];
   evt_t e_a;
   evt_t e_b;

   sdram_aref_if ifa ();
   sdram_aref_if ifb ();

   sdram_aref #(.T_REFI(20), .T_RP(2), .T_RC(7), .NUM_REF(2)) dut_a (
      .clk (clk),
      .rst (rst),
      .io  (ifa)
   );

   sdram_aref #(.T_REFI(30), .T_RP(2), .T_RC(3), .NUM_REF(1)) dut_b (
      .clk (clk),
      .rst (rst),
      .io  (ifb)
   );

   always #5 clk = ~clk;

   // Cycle n is the interval following rising edge n.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic evt_t mk(input int c, input logic [19:0] b, input logic d);
      evt_t e;
      e.cyc  = c;
      e.bus  = b;
      e.done = d;
      return e;
   endfunction

   // Push one full dut_a sequence (PRE, 2 x REF, done) starting with PRE at cycle p.
   task automatic push_seq_a(input int p);
      q_a.push_back(mk(p,      PRE_BUS, 1'b0));
      q_a.push_back(mk(p + 2,  REF_BUS, 1'b0));
      q_a.push_back(mk(p + 9,  REF_BUS, 1'b0));
      q_a.push_back(mk(p + 16, NOP_BUS, 1'b1));
   endtask

   // Push one full dut_b sequence (PRE, 1 x REF, done) starting with PRE at cycle p.
   task automatic push_seq_b(input int p);
      q_b.push_back(mk(p,     PRE_BUS, 1'b0));
      q_b.push_back(mk(p + 2, REF_BUS, 1'b0));
      q_b.push_back(mk(p + 5, NOP_BUS, 1'b1));
   endtask

   // Monitor for dut_a: any command or done pulse must match the head of the queue.
   always @(negedge clk) begin
      if (ifa.aref_bus !== NOP_BUS || ifa.ref_done !== 1'b0) begin
         if (q_a.size() == 0) begin
            check("a_unexpected_event", {11'h0, ifa.ref_done, ifa.aref_bus}, {12'h0, NOP_BUS});
         end else begin
            e_a = q_a.pop_front();
            check("a_evt_cycle", cyc, e_a.cyc);
            check("a_evt_bus", {12'h0, ifa.aref_bus}, {12'h0, e_a.bus});
            check("a_evt_done", {31'h0, ifa.ref_done}, {31'h0, e_a.done});
         end
      end
   end

   // Monitor for dut_b.
   always @(negedge clk) begin
      if (ifb.aref_bus !== NOP_BUS || ifb.ref_done !== 1'b0) begin
         if (q_b.size() == 0) begin
            check("b_unexpected_event", {11'h0, ifb.ref_done, ifb.aref_bus}, {12'h0, NOP_BUS});
         end else begin
            e_b = q_b.pop_front();
            check("b_evt_cycle", cyc, e_b.cyc);
            check("b_evt_bus", {12'h0, ifb.aref_bus}, {12'h0, e_b.bus});
            check("b_evt_done", {31'h0, ifb.ref_done}, {31'h0, e_b.done});
         end
      end
   end

   initial begin
      ifa.init_done = 1'b0;
      ifa.ref_en    = 1'b0;
      ifb.init_done = 1'b0;
      ifb.ref_en    = 1'b0;
      #1 rst = 1'b1;

      // Reset state.
      goto(1);
      check("rst_bus_a", {12'h0, ifa.aref_bus}, {12'h0, NOP_BUS});
      check("rst_req_a", {31'h0, ifa.ref_req}, 32'h0);
      check("rst_done_a", {31'h0, ifa.ref_done}, 32'h0);
      check("rst_ovr_a", {31'h0, ifa.ref_overrun}, 32'h0);
      check("rst_bus_b", {12'h0, ifb.aref_bus}, {12'h0, NOP_BUS});
      goto(2);
      rst = 1'b0;

      // Basic sequence: init_done at cycle 5, grant held high (ignored while no request).
      push_seq_a(26);
      goto(5);
      ifa.init_done = 1'b1;
      ifa.ref_en    = 1'b1;
      goto(24);
      check("s1_req_before_tick", {31'h0, ifa.ref_req}, 32'h0);
      goto(25);
      check("s1_req_at_tick", {31'h0, ifa.ref_req}, 32'h1);
      goto(43);
      check("s1_req_after_done", {31'h0, ifa.ref_req}, 32'h0);
      ifa.ref_en    = 1'b0;
      ifa.init_done = 1'b0;

      // Saturation and overrun on dut_b, then drain with three back-to-back sequences.
      push_seq_b(171);
      push_seq_b(178);
      push_seq_b(185);
      goto(50);
      ifb.init_done = 1'b1;
      goto(79);
      check("s2_req_before_tick", {31'h0, ifb.ref_req}, 32'h0);
      goto(80);
      check("s2_req_first_tick", {31'h0, ifb.ref_req}, 32'h1);
      goto(169);
      check("s2_no_overrun_yet", {31'h0, ifb.ref_overrun}, 32'h0);
      goto(170);
      check("s2_overrun_4th_tick", {31'h0, ifb.ref_overrun}, 32'h1);
      ifb.ref_en = 1'b1;
      goto(190);
      check("s2_req_before_last_done", {31'h0, ifb.ref_req}, 32'h1);
      goto(191);
      check("s2_req_drained", {31'h0, ifb.ref_req}, 32'h0);
      check("s2_overrun_sticky", {31'h0, ifb.ref_overrun}, 32'h1);
      ifb.ref_en    = 1'b0;
      ifb.init_done = 1'b0;

      // Tick coincides with ref_done at pend=1: pend holds and the next sequence follows at once.
      push_seq_a(223);
      push_seq_a(241);
      goto(200);
      ifa.init_done = 1'b1;
      goto(220);
      check("s3_req_tick", {31'h0, ifa.ref_req}, 32'h1);
      goto(222);
      ifa.ref_en = 1'b1;
      goto(240);
      check("s3_req_held_on_coincide", {31'h0, ifa.ref_req}, 32'h1);
      goto(258);
      check("s3_req_drained", {31'h0, ifa.ref_req}, 32'h0);
      check("s3_no_overrun", {31'h0, ifa.ref_overrun}, 32'h0);
      ifa.ref_en    = 1'b0;
      ifa.init_done = 1'b0;

      // Grant pulsed during WAIT_RC must not disturb the command stream.
      push_seq_a(291);
      goto(270);
      ifa.init_done = 1'b1;
      goto(290);
      ifa.ref_en = 1'b1;
      goto(291);
      ifa.ref_en = 1'b0;
      goto(296);
      ifa.ref_en = 1'b1;
      goto(297);
      ifa.ref_en = 1'b0;
      goto(308);
      check("s4_req_after_done", {31'h0, ifa.ref_req}, 32'h0);
      ifa.init_done = 1'b0;

      // init_done dropped mid-sequence: sequence completes, no further requests.
      push_seq_a(341);
      goto(320);
      ifa.init_done = 1'b1;
      ifa.ref_en    = 1'b1;
      goto(341);
      check("s5_req_during_seq", {31'h0, ifa.ref_req}, 32'h1);
      goto(345);
      ifa.init_done = 1'b0;
      goto(346);
      check("s5_req_cleared", {31'h0, ifa.ref_req}, 32'h0);
      goto(380);
      check("s5_req_stays_low", {31'h0, ifa.ref_req}, 32'h0);
      ifa.ref_en = 1'b0;

      // Reset asserted in WAIT_RP: sequence abandoned, outputs idle in the same cycle.
      q_a.push_back(mk(411, PRE_BUS, 1'b0));
      goto(390);
      ifa.init_done = 1'b1;
      ifa.ref_en    = 1'b1;
      goto(412);
      rst = 1'b1;
      #1;
      check("s6_rst_bus", {12'h0, ifa.aref_bus}, {12'h0, NOP_BUS});
      check("s6_rst_req", {31'h0, ifa.ref_req}, 32'h0);
      check("s6_rst_done", {31'h0, ifa.ref_done}, 32'h0);
      check("s6_rst_clears_overrun_b", {31'h0, ifb.ref_overrun}, 32'h0);
      push_seq_a(435);
      goto(414);
      rst = 1'b0;
      goto(433);
      check("s6_req_before_new_tick", {31'h0, ifa.ref_req}, 32'h0);
      goto(434);
      check("s6_req_new_tick", {31'h0, ifa.ref_req}, 32'h1);
      goto(452);
      check("s6_req_after_done", {31'h0, ifa.ref_req}, 32'h0);
      ifa.ref_en    = 1'b0;
      ifa.init_done = 1'b0;

      goto(470);
      check("q_a_drained", q_a.size(), 32'h0);
      check("q_b_drained", q_b.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
